// File: rtl/cplx_divider.sv
// Sequential fixed-point complex divider q = a*conj(b)/|b|^2 in signed Q1.(WIDTH-1).
// A single restoring divider produces the real quotient magnitude, then the imaginary one.
module cplx_divider #(
    parameter int WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    di_en,
    input  logic signed [WIDTH-1:0] a_re,
    input  logic signed [WIDTH-1:0] a_im,
    input  logic signed [WIDTH-1:0] b_re,
    input  logic signed [WIDTH-1:0] b_im,
    output logic                    busy,
    output logic                    do_en,
    output logic signed [WIDTH-1:0] q_re,
    output logic signed [WIDTH-1:0] q_im,
    output logic                    ovf,
    output logic                    div_zero
);
    localparam int PW = 2 * WIDTH + 1;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 2);

    typedef enum logic [2:0] {IDLE, MULT, DIV_RE, DIV_IM, DONE} state_t;
    state_t state, state_nxt;

    logic signed [WIDTH-1:0] a_re_p0, a_im_p0, b_re_p0, b_im_p0;
    logic [PW-1:0]           mag_re_p1, mag_im_p1, den_p1;
    logic                    neg_re_p1, neg_im_p1, ovf_re_p1, ovf_im_p1, dz_p1;
    logic [PW-1:0]           rem_p2;
    logic [WIDTH-2:0]        quo_p2, m_re_p2;
    logic [CW-1:0]           cnt;

    logic signed [2*WIDTH-1:0] p_rr, p_ii, p_ir, p_ri, s_rr, s_ii;
    logic signed [PW-1:0]      num_re, num_im;
    logic [PW-1:0]             mag_re, mag_im, den, rem_sh, rem_nxt;
    logic [WIDTH-2:0]          quo_nxt;
    logic                      ge;

    // Symmetric saturation: the most-negative code is never produced.
    function automatic logic signed [WIDTH-1:0] form_q(input logic neg, input logic sat,
                                                       input logic dz, input logic [WIDTH-2:0] m);
        logic [WIDTH-1:0] mag;
        mag = sat ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b0, m};
        if (dz)
            return '0;
        return neg ? $signed(~mag + 1'b1) : $signed(mag);
    endfunction

    assign busy = (state != IDLE);

    always_comb begin
        p_rr    = a_re_p0 * b_re_p0;
        p_ii    = a_im_p0 * b_im_p0;
        p_ir    = a_im_p0 * b_re_p0;
        p_ri    = a_re_p0 * b_im_p0;
        s_rr    = b_re_p0 * b_re_p0;
        s_ii    = b_im_p0 * b_im_p0;
        num_re  = $signed({p_rr[2*WIDTH-1], p_rr}) + $signed({p_ii[2*WIDTH-1], p_ii});
        num_im  = $signed({p_ir[2*WIDTH-1], p_ir}) - $signed({p_ri[2*WIDTH-1], p_ri});
        den     = {1'b0, s_rr} + {1'b0, s_ii};
        mag_re  = num_re[PW-1] ? $unsigned(-num_re) : $unsigned(num_re);
        mag_im  = num_im[PW-1] ? $unsigned(-num_im) : $unsigned(num_im);
        rem_sh  = rem_p2 << 1;
        ge      = (rem_sh >= den_p1);
        rem_nxt = ge ? (rem_sh - den_p1) : rem_sh;
        quo_nxt = {quo_p2[WIDTH-3:0], ge};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (di_en) state_nxt = MULT;
            MULT:    state_nxt = DIV_RE;
            DIV_RE:  if (cnt == LAST) state_nxt = DIV_IM;
            DIV_IM:  if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            do_en     <= 1'b0;
            q_re      <= '0;
            q_im      <= '0;
            ovf       <= 1'b0;
            div_zero  <= 1'b0;
            a_re_p0   <= '0;
            a_im_p0   <= '0;
            b_re_p0   <= '0;
            b_im_p0   <= '0;
            mag_re_p1 <= '0;
            mag_im_p1 <= '0;
            den_p1    <= '0;
            neg_re_p1 <= 1'b0;
            neg_im_p1 <= 1'b0;
            ovf_re_p1 <= 1'b0;
            ovf_im_p1 <= 1'b0;
            dz_p1     <= 1'b0;
            rem_p2    <= '0;
            quo_p2    <= '0;
            m_re_p2   <= '0;
            cnt       <= '0;
        end else begin
            state <= state_nxt;
            do_en <= 1'b0;
            case (state)
                // p0: operand capture
                IDLE: if (di_en) begin
                    a_re_p0 <= a_re;
                    a_im_p0 <= a_im;
                    b_re_p0 <= b_re;
                    b_im_p0 <= b_im;
                end
                // p1: full-precision products, sign/magnitude split, flags
                MULT: begin
                    mag_re_p1 <= mag_re;
                    mag_im_p1 <= mag_im;
                    den_p1    <= den;
                    neg_re_p1 <= num_re[PW-1];
                    neg_im_p1 <= num_im[PW-1];
                    ovf_re_p1 <= (mag_re >= den);
                    ovf_im_p1 <= (mag_im >= den);
                    dz_p1     <= (den == '0);
                    rem_p2    <= mag_re;
                    quo_p2    <= '0;
                    cnt       <= '0;
                end
                // p2: shared restoring divider, real part then imaginary part
                DIV_RE: if (cnt == LAST) begin
                    m_re_p2 <= quo_nxt;
                    rem_p2  <= mag_im_p1;
                    quo_p2  <= '0;
                    cnt     <= '0;
                end else begin
                    rem_p2  <= rem_nxt;
                    quo_p2  <= quo_nxt;
                    cnt     <= cnt + 1'b1;
                end
                DIV_IM: begin
                    rem_p2  <= rem_nxt;
                    quo_p2  <= quo_nxt;
                    cnt     <= cnt + 1'b1;
                end
                // result stage: outputs and do_en land together on the exit edge
                DONE: begin
                    q_re     <= form_q(neg_re_p1, ovf_re_p1, dz_p1, m_re_p2);
                    q_im     <= form_q(neg_im_p1, ovf_im_p1, dz_p1, quo_p2);
                    ovf      <= (ovf_re_p1 | ovf_im_p1) & ~dz_p1;
                    div_zero <= dz_p1;
                    do_en    <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cplx_divider.sv
// Directed self-checking bench for cplx_divider (WIDTH=16) with hand-computed quotients.
module tb_cplx_divider;
    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         di_en = 1'b0;
    logic [W-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic         busy, do_en, ovf, div_zero;
    logic [W-1:0] q_re, q_im;

    int total = 0;
    int bad = 0;
    int do_cnt = 0;
    int lat, lat2, c0;

    cplx_divider #(.WIDTH(W)) dut (
        .clock(clock), .reset_n(reset_n), .di_en(di_en),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .busy(busy), .do_en(do_en), .q_re(q_re), .q_im(q_im),
        .ovf(ovf), .div_zero(div_zero)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (do_en) do_cnt <= do_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Waits up to 40 negedges for do_en; lat = negedges counted, 0 on timeout.
    task automatic wait_done(output int l);
        bit hit;
        hit = 0;
        l = 0;
        for (int k = 1; k <= 40 && !hit; k++) begin
            @(negedge clock);
            if (do_en) begin
                l = k;
                hit = 1;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ar, ai, br, bi,
                          input logic [W-1:0] qr, qi, input logic ov, dz);
        int l;
        @(negedge clock);
        a_re = ar; a_im = ai; b_re = br; b_im = bi;
        di_en = 1'b1;
        @(negedge clock);
        di_en = 1'b0;
        a_re = ~ar; a_im = ~ai; b_re = ~br; b_im = ~bi;
        check({tag, "_busy"}, busy, 1);
        wait_done(l);
        check({tag, "_lat"}, l, 32);
        check({tag, "_qre"}, q_re, qr);
        check({tag, "_qim"}, q_im, qi);
        check({tag, "_ovf"}, ovf, ov);
        check({tag, "_dz"}, div_zero, dz);
        @(negedge clock);
        check({tag, "_pulse"}, do_en, 0);
        check({tag, "_hold"}, q_re, qr);
    endtask

    initial begin
        #1;
        check("rst_do_en", do_en, 0);
        check("rst_busy", busy, 0);
        check("rst_qre", q_re, 0);
        check("rst_qim", q_im, 0);
        check("rst_ovf", ovf, 0);
        check("rst_dz", div_zero, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        run_op("re_re",   16'h2000, 16'h0000, 16'h4000, 16'h0000, 16'h4000, 16'h0000, 0, 0);
        run_op("im_im",   16'h0000, 16'h2000, 16'h0000, 16'h4000, 16'h4000, 16'h0000, 0, 0);
        run_op("re_im",   16'h2000, 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'hC000, 0, 0);
        run_op("ovf_pos", 16'h4000, 16'h0000, 16'h2000, 16'h0000, 16'h7FFF, 16'h0000, 1, 0);
        run_op("ovf_neg", 16'hC000, 16'h0000, 16'h2000, 16'h0000, 16'h8001, 16'h0000, 1, 0);
        run_op("dzero",   16'h1234, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1);
        run_op("third",   16'h1000, 16'h0000, 16'h3000, 16'h0000, 16'h2AAA, 16'h0000, 0, 0);
        run_op("third_n", 16'hF000, 16'h0000, 16'h3000, 16'h0000, 16'hD556, 16'h0000, 0, 0);
        run_op("diag",    16'h1000, 16'h1000, 16'h4000, 16'h4000, 16'h2000, 16'h0000, 0, 0);
        run_op("mixed",   16'h2000, 16'h1000, 16'h4000, 16'h0000, 16'h4000, 16'h2000, 0, 0);

        // di_en held high: operands sampled only in IDLE, one result per 33 cycles
        @(negedge clock);
        a_re = 16'h2000; a_im = 16'h0000; b_re = 16'h4000; b_im = 16'h0000;
        di_en = 1'b1;
        @(negedge clock);
        a_re = 16'h1000; a_im = 16'h0000; b_re = 16'h3000; b_im = 16'h0000;
        wait_done(lat);
        check("held_lat1", lat, 32);
        check("held_q1", q_re, 16'h4000);
        wait_done(lat2);
        di_en = 1'b0;
        check("held_period", lat2, 33);
        check("held_q2", q_re, 16'h2AAA);
        @(negedge clock);
        c0 = do_cnt;
        repeat (40) @(negedge clock);
        check("held_no_extra", do_cnt - c0, 0);

        // reset in the middle of an operation aborts it
        @(negedge clock);
        a_re = 16'h2000; a_im = 16'h0000; b_re = 16'h4000; b_im = 16'h0000;
        di_en = 1'b1;
        @(negedge clock);
        di_en = 1'b0;
        repeat (9) @(negedge clock);
        check("mid_busy_pre", busy, 1);
        reset_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_do_en", do_en, 0);
        check("mid_qre", q_re, 0);
        check("mid_qim", q_im, 0);
        check("mid_ovf", ovf, 0);
        check("mid_dz", div_zero, 0);
        @(negedge clock);
        reset_n = 1'b1;
        c0 = do_cnt;
        repeat (40) @(negedge clock);
        check("mid_no_do_en", do_cnt - c0, 0);

        run_op("post_rst", 16'h2000, 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'hC000, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
